// File: rtl/eu_issue_port_pkg.sv
// -----------------------------------------------------------------------------
// eu_issue_port_pkg
// Shared field layout for the scheduler/EU port buses and the branch
// resolution bus, plus the functional-unit type encoding used by the issue
// port and its speculation-tag filter.
//
// Bus layouts (LSB first):
//   FUBRresp : [0] VALID, [1] MISPRED, [5:2] SPECTAG
//   Port_E2S : [0] READY, [16:1] FUMASK
//   Port_S2E : [0] VALID, [4:1] FUTYPE, [8:5] SPECTAG, [40:9] PC, [56:41] UOP
// -----------------------------------------------------------------------------
package eu_issue_port_pkg;

  // Field widths
  localparam int SPECTAG_LEN = 4;
  localparam int FU_MASK_LEN = 16;
  localparam int FUTYPE_LEN  = 4;
  localparam int PC_LEN      = 32;
  localparam int UOP_LEN     = 16;

  // Branch resolution bus
  localparam int FUBR_RESULT_VALID   = 0;
  localparam int FUBR_RESULT_MISPRED = 1;
  localparam int FUBR_RESULT_SPECTAG = 2;
  localparam int FUBR_RESULT_LEN     = FUBR_RESULT_SPECTAG + SPECTAG_LEN;

  // EU -> scheduler
  localparam int PORT_E2S_READY  = 0;
  localparam int PORT_E2S_FUMASK = 1;
  localparam int PORT_E2S_LEN    = PORT_E2S_FUMASK + FU_MASK_LEN;

  // Scheduler -> EU
  localparam int PORT_S2E_VALID   = 0;
  localparam int PORT_S2E_FUTYPE  = 1;
  localparam int PORT_S2E_SPECTAG = PORT_S2E_FUTYPE + FUTYPE_LEN;
  localparam int PORT_S2E_PC      = PORT_S2E_SPECTAG + SPECTAG_LEN;
  localparam int PORT_S2E_UOP     = PORT_S2E_PC + PC_LEN;
  localparam int PORT_S2E_LEN     = PORT_S2E_UOP + UOP_LEN;

  localparam int ISSUE_PORT_DEPTH = 2;

  // Functional-unit type: an index into the EU's FUMASK
  typedef enum logic [FUTYPE_LEN-1:0] {
    FU_IALU = 4'd0,
    FU_IMUL = 4'd1,
    FU_IDIV = 4'd2,
    FU_BR   = 4'd3,
    FU_LSU  = 4'd4,
    FU_FALU = 4'd5,
    FU_FMUL = 4'd6,
    FU_FDIV = 4'd7
  } futype_e;

  // True when the EU advertises the unit selected by futype
  function automatic logic fu_legal(input logic [FU_MASK_LEN-1:0] mask,
                                    input logic [FUTYPE_LEN-1:0]  futype);
    return mask[futype];
  endfunction

endpackage

// File: rtl/eu_issue_port_spectag_filter.sv
// -----------------------------------------------------------------------------
// spectag_filter
// Combinational view of one Port_S2E word against the current branch
// resolution. Flags the word as killed when a mispredicted branch's tag
// overlaps the word's speculation tag, and clears the resolved tag bit from
// the word when the branch was predicted correctly.
//
// Ports:
//   word_i   : Port_S2E-format word under test
//   fubr_i   : FUBRresp branch resolution bus
//   killed_o : word depends on a mispredicted branch
//   word_o   : word with correctly-resolved tag bits removed
// -----------------------------------------------------------------------------
module spectag_filter
  import eu_issue_port_pkg::*;
(
  input  logic [PORT_S2E_LEN-1:0]    word_i,
  input  logic [FUBR_RESULT_LEN-1:0] fubr_i,
  output logic                       killed_o,
  output logic [PORT_S2E_LEN-1:0]    word_o
);

  logic [SPECTAG_LEN-1:0] tag_s;
  logic [SPECTAG_LEN-1:0] br_tag_s;
  logic                   br_valid_s;
  logic                   br_mispred_s;

  assign tag_s        = word_i[PORT_S2E_SPECTAG +: SPECTAG_LEN];
  assign br_tag_s     = fubr_i[FUBR_RESULT_SPECTAG +: SPECTAG_LEN];
  assign br_valid_s   = fubr_i[FUBR_RESULT_VALID];
  assign br_mispred_s = fubr_i[FUBR_RESULT_MISPRED];

  // Kill on overlap with a mispredicted tag; retire the tag on a correct one
  always_comb begin
    killed_o = br_valid_s & br_mispred_s & (|(tag_s & br_tag_s));
    word_o   = word_i;
    if (br_valid_s & ~br_mispred_s) begin
      word_o[PORT_S2E_SPECTAG +: SPECTAG_LEN] = tag_s & ~br_tag_s;
    end else begin
      word_o[PORT_S2E_SPECTAG +: SPECTAG_LEN] = tag_s;
    end
  end

endmodule

// File: rtl/eu_issue_port.sv
// -----------------------------------------------------------------------------
// eu_issue_port
// Scheduler-side end of the scheduler-to-EU port. Buffers selected
// instructions in a 2-entry in-order queue (slot0 is always the head) and
// presents the head to the EU on any cycle the EU reports READY. Buffered and
// incoming words are discarded on Flush or when a mispredicted branch's tag
// hits them; correctly predicted tags are cleared from everything held.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   Flush        : empty the buffer and suppress this cycle's issue
//   FUBRresp     : branch resolution (VALID, MISPRED, SPECTAG)
//   Port_E2S     : from EU (READY, FUMASK)
//   Port_S2E     : to EU; all zeros whenever VALID is low
//   IssueValid   : select logic offers IssueInstr
//   IssueInstr   : offered word (its VALID bit is ignored)
//   IssueReady   : buffer can accept this cycle
//   PortFUMask   : EU functional-unit mask, passed through combinationally
//   IllegalFU    : sticky; an accepted word targeted an absent unit
// -----------------------------------------------------------------------------
module eu_issue_port
  import eu_issue_port_pkg::*;
#(
  parameter int PORTID = -1,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       Flush,
  input  logic [FUBR_RESULT_LEN-1:0] FUBRresp,
  input  logic [PORT_E2S_LEN-1:0]    Port_E2S,
  output logic [PORT_S2E_LEN-1:0]    Port_S2E,
  input  logic                       IssueValid,
  input  logic [PORT_S2E_LEN-1:0]    IssueInstr,
  output logic                       IssueReady,
  output logic [FU_MASK_LEN-1:0]     PortFUMask,
  output logic                       IllegalFU
);

  // Elaboration-time parameter sanity
  if (DEPTH != ISSUE_PORT_DEPTH) begin : g_depth_chk
    $error("eu_issue_port: only DEPTH=2 is supported");
  end
  if (PORTID < -1) begin : g_portid_chk
    $error("eu_issue_port: PORTID must be -1 or a port number");
  end

  localparam logic [PORT_S2E_LEN-1:0] VALID_BIT = {{(PORT_S2E_LEN-1){1'b0}}, 1'b1};

  // Queue state: slot valids (v1 implies v0) and stored words
  logic                    v0_q, v0_d;
  logic                    v1_q, v1_d;
  logic [PORT_S2E_LEN-1:0] w0_q, w0_d;
  logic [PORT_S2E_LEN-1:0] w1_q, w1_d;
  logic                    illegal_q, illegal_d;

  // Filtered views of both slots and the incoming word
  logic                    kill0_s, kill1_s, kill_in_s;
  logic [PORT_S2E_LEN-1:0] w0c_s, w1c_s, win_s;

  logic ready_s;
  logic accept_s;
  logic in_legal_s;
  logic issue_s;
  logic keep0_s;
  logic keep1_s;
  logic push_s;

  spectag_filter u_filt_slot0 (
    .word_i   (w0_q),
    .fubr_i   (FUBRresp),
    .killed_o (kill0_s),
    .word_o   (w0c_s)
  );

  spectag_filter u_filt_slot1 (
    .word_i   (w1_q),
    .fubr_i   (FUBRresp),
    .killed_o (kill1_s),
    .word_o   (w1c_s)
  );

  spectag_filter u_filt_in (
    .word_i   (IssueInstr),
    .fubr_i   (FUBRresp),
    .killed_o (kill_in_s),
    .word_o   (win_s)
  );

  assign ready_s    = Port_E2S[PORT_E2S_READY];
  assign PortFUMask = Port_E2S[PORT_E2S_FUMASK +: FU_MASK_LEN];

  // Acceptance looks only at registered occupancy, so a same-cycle pop
  // never re-opens a full buffer.
  assign IssueReady = ~v1_q & ~rst;
  assign accept_s   = IssueValid & IssueReady;
  assign in_legal_s = fu_legal(PortFUMask, IssueInstr[PORT_S2E_FUTYPE +: FUTYPE_LEN]);

  // A killed head is never issued, even with READY high
  assign issue_s = v0_q & ready_s & ~Flush & ~kill0_s & ~rst;

  // Only a live issue drives the bus; otherwise it is held at zero
  assign Port_S2E  = issue_s ? (w0c_s | VALID_BIT) : {PORT_S2E_LEN{1'b0}};
  assign IllegalFU = illegal_q & ~rst;

  assign keep0_s = v0_q & ~kill0_s & ~issue_s;
  assign keep1_s = v1_q & ~kill1_s;
  // Killed or illegal incoming words are accepted but never stored
  assign push_s  = accept_s & ~kill_in_s & in_legal_s;

  // Next queue state: compact survivors toward slot0, then append the new word
  always_comb begin
    v0_d      = 1'b0;
    v1_d      = 1'b0;
    w0_d      = w0_q;
    w1_d      = w1_q;
    illegal_d = illegal_q;
    if (Flush) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end else begin
      if (keep0_s) begin
        v0_d = 1'b1;
        w0_d = w0c_s;
        if (keep1_s) begin
          v1_d = 1'b1;
          w1_d = w1c_s;
        end else begin
          v1_d = 1'b0;
        end
      end else if (keep1_s) begin
        v0_d = 1'b1;
        w0_d = w1c_s;
      end else begin
        v0_d = 1'b0;
      end

      // accept implies v1_q=0, so at most one survivor precedes the new word
      if (push_s) begin
        if (v0_d) begin
          v1_d = 1'b1;
          w1_d = win_s;
        end else begin
          v0_d = 1'b1;
          w0_d = win_s;
        end
      end else begin
        v1_d = v1_d;
      end

      if (accept_s & ~in_legal_s) begin
        illegal_d = 1'b1;
      end else begin
        illegal_d = illegal_q;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      w0_q      <= {PORT_S2E_LEN{1'b0}};
      w1_q      <= {PORT_S2E_LEN{1'b0}};
      illegal_q <= 1'b0;
    end else begin
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      w0_q      <= w0_d;
      w1_q      <= w1_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_eu_issue_port.sv
module tb_eu_issue_port;
  import eu_issue_port_pkg::*;

  logic                       clk;
  logic                       rst;
  logic                       Flush;
  logic [FUBR_RESULT_LEN-1:0] FUBRresp;
  logic [PORT_E2S_LEN-1:0]    Port_E2S;
  logic [PORT_S2E_LEN-1:0]    Port_S2E;
  logic                       IssueValid;
  logic [PORT_S2E_LEN-1:0]    IssueInstr;
  logic                       IssueReady;
  logic [FU_MASK_LEN-1:0]     PortFUMask;
  logic                       IllegalFU;

  logic                       ready;
  logic [FU_MASK_LEN-1:0]     fumask;

  int n_checks = 0;
  int n_errors = 0;
  logic [PORT_S2E_LEN-1:0] exp_q[$];

  assign Port_E2S = {fumask, ready};

  eu_issue_port #(.PORTID(0), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .Flush      (Flush),
    .FUBRresp   (FUBRresp),
    .Port_E2S   (Port_E2S),
    .Port_S2E   (Port_S2E),
    .IssueValid (IssueValid),
    .IssueInstr (IssueInstr),
    .IssueReady (IssueReady),
    .PortFUMask (PortFUMask),
    .IllegalFU  (IllegalFU)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PORT_S2E_LEN-1:0] mkw(input logic [3:0] fut,
                                                   input logic [3:0] tag,
                                                   input logic [31:0] pc);
    logic [PORT_S2E_LEN-1:0] w;
    w = '0;
    w[PORT_S2E_FUTYPE +: 4]   = fut;
    w[PORT_S2E_SPECTAG +: 4]  = tag;
    w[PORT_S2E_PC +: 32]      = pc;
    w[PORT_S2E_UOP +: 16]     = pc[15:0] ^ 16'h5a5a;
    return w;
  endfunction

  function automatic logic [FUBR_RESULT_LEN-1:0] mkbr(input logic v, input logic mp,
                                                       input logic [3:0] tag);
    return {tag, mp, v};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every valid Port_S2E must match the next expected word
  always @(negedge clk) begin
    if (Port_S2E[PORT_S2E_VALID] === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got pc %h with nothing expected",
                 Port_S2E[PORT_S2E_PC +: 32]);
      end else begin
        logic [PORT_S2E_LEN-1:0] e;
        e = exp_q.pop_front();
        if (Port_S2E !== e) begin
          n_errors++;
          $display("FAIL sb_word: got %h expected %h", Port_S2E, e);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [PORT_S2E_LEN-1:0] wa, wb, wc, wd, we, wf, wg, wh, wi, wj, wk, wl, wm, wn;

  initial begin
    wa = mkw(FU_IALU, 4'b0000, 32'h8000_0000);
    wb = mkw(FU_IALU, 4'b0000, 32'h8000_0010);
    wc = mkw(FU_IMUL, 4'b0000, 32'h8000_0014);
    wd = mkw(FU_LSU,  4'b0000, 32'h8000_0018);
    we = mkw(FU_IALU, 4'b0001, 32'h8000_0100);
    wf = mkw(FU_BR,   4'b0010, 32'h8000_0104);
    wg = mkw(FU_FMUL, 4'b0100, 32'h8000_0200);
    wh = mkw(FU_FALU, 4'b0110, 32'h8000_0204);
    wi = mkw(FU_IALU, 4'b0000, 32'h8000_0300);
    wj = mkw(FU_IALU, 4'b0000, 32'h8000_0304);
    wk = mkw(FU_FDIV, 4'b0000, 32'h8000_0400);
    wl = mkw(FU_IALU, 4'b0000, 32'h8000_0404);
    wm = mkw(FU_IALU, 4'b0000, 32'h8000_0500);
    wn = mkw(FU_IALU, 4'b0000, 32'h8000_0504);

    rst = 1'b1; Flush = 1'b0; FUBRresp = '0; ready = 1'b0; fumask = 16'h00ff;
    IssueValid = 1'b0; IssueInstr = '0;

    // Reset state
    @(negedge clk);
    chk("rst_port", 64'(Port_S2E), 64'd0);
    chk("rst_ready", 64'(IssueReady), 64'd0);
    chk("rst_illegal", 64'(IllegalFU), 64'd0);
    chk("fumask_pass", 64'(PortFUMask), 64'h00ff);
    cyc();
    rst = 1'b0;

    // Basic handshake
    ready = 1'b1; IssueValid = 1'b1; IssueInstr = wa; exp_q.push_back(wa | 57'd1);
    @(negedge clk);
    chk("t1_ready", 64'(IssueReady), 64'd1);
    chk("t1_nobypass", 64'(Port_S2E[0]), 64'd0);
    cyc(); IssueValid = 1'b0;
    @(negedge clk);
    chk("t1_valid", 64'(Port_S2E[0]), 64'd1);
    chk("t1_pc", 64'(Port_S2E[PORT_S2E_PC +: 32]), 64'h8000_0000);
    cyc();
    @(negedge clk);
    chk("t1_idle", 64'(Port_S2E), 64'd0);
    cyc();

    // Backpressure
    ready = 1'b0; IssueValid = 1'b1; IssueInstr = wb; exp_q.push_back(wb | 57'd1);
    @(negedge clk);
    chk("t2_ready0", 64'(IssueReady), 64'd1);
    cyc(); IssueInstr = wc; exp_q.push_back(wc | 57'd1);
    @(negedge clk);
    chk("t2_ready1", 64'(IssueReady), 64'd1);
    cyc(); IssueInstr = wd; exp_q.push_back(wd | 57'd1);
    @(negedge clk);
    chk("t2_full", 64'(IssueReady), 64'd0);
    chk("t2_hold", 64'(Port_S2E), 64'd0);
    cyc(); ready = 1'b1;
    @(negedge clk);
    chk("t2_noreopen", 64'(IssueReady), 64'd0);
    cyc();
    @(negedge clk);
    chk("t2_reopen", 64'(IssueReady), 64'd1);
    cyc(); IssueValid = 1'b0;
    @(negedge clk);
    chk("t2_third", 64'(Port_S2E[0]), 64'd1);
    cyc();
    @(negedge clk);
    chk("t2_drained", 64'(Port_S2E), 64'd0);
    chk("t2_ready_end", 64'(IssueReady), 64'd1);
    cyc();

    // Kill compaction; head kill beats issue
    ready = 1'b0; IssueValid = 1'b1; IssueInstr = we;
    cyc(); IssueInstr = wf;
    cyc(); IssueValid = 1'b0; ready = 1'b1; FUBRresp = mkbr(1'b1, 1'b1, 4'b0001);
    @(negedge clk);
    chk("t3_killwins", 64'(Port_S2E), 64'd0);
    cyc(); FUBRresp = '0; exp_q.push_back(wf | 57'd1);
    @(negedge clk);
    chk("t3_count1", 64'(IssueReady), 64'd1);
    chk("t3_slot1_issues", 64'(Port_S2E[PORT_S2E_PC +: 32]), 64'h8000_0104);
    cyc();
    @(negedge clk);
    chk("t3_empty", 64'(Port_S2E), 64'd0);
    cyc();

    // Correct prediction clears tag from held and incoming words
    ready = 1'b0; IssueValid = 1'b1; IssueInstr = wg;
    cyc(); IssueInstr = wh; FUBRresp = mkbr(1'b1, 1'b0, 4'b0100);
    cyc(); IssueValid = 1'b0; FUBRresp = mkbr(1'b1, 1'b1, 4'b0100);
    @(negedge clk);
    chk("t4_hold", 64'(Port_S2E), 64'd0);
    cyc(); FUBRresp = '0; ready = 1'b1;
    exp_q.push_back(mkw(FU_FMUL, 4'b0000, 32'h8000_0200) | 57'd1);
    exp_q.push_back(mkw(FU_FALU, 4'b0010, 32'h8000_0204) | 57'd1);
    @(negedge clk);
    chk("t4_survive", 64'(Port_S2E[0]), 64'd1);
    cyc();
    @(negedge clk);
    chk("t4_second", 64'(Port_S2E[0]), 64'd1);
    cyc();

    // Flush versus issue
    ready = 1'b0; IssueValid = 1'b1; IssueInstr = wi;
    cyc(); IssueInstr = wj; Flush = 1'b1; ready = 1'b1;
    @(negedge clk);
    chk("t5_flush", 64'(Port_S2E), 64'd0);
    cyc(); Flush = 1'b0; IssueValid = 1'b0;
    @(negedge clk);
    chk("t5_empty", 64'(Port_S2E), 64'd0);
    chk("t5_ready", 64'(IssueReady), 64'd1);
    cyc();

    // IllegalFU
    fumask = 16'h0001; ready = 1'b1; IssueValid = 1'b1; IssueInstr = wk;
    @(negedge clk);
    chk("t6_flag_pre", 64'(IllegalFU), 64'd0);
    cyc(); IssueValid = 1'b0;
    @(negedge clk);
    chk("t6_flag", 64'(IllegalFU), 64'd1);
    chk("t6_dropped", 64'(Port_S2E), 64'd0);
    cyc(); IssueValid = 1'b1; IssueInstr = wl; exp_q.push_back(wl | 57'd1);
    cyc(); IssueValid = 1'b0;
    @(negedge clk);
    chk("t6_legal_issue", 64'(Port_S2E[0]), 64'd1);
    chk("t6_sticky", 64'(IllegalFU), 64'd1);
    cyc();

    // Synchronous reset mid-queue
    ready = 1'b0; IssueValid = 1'b1; IssueInstr = wm;
    cyc(); IssueInstr = wn;
    cyc(); IssueValid = 1'b0; rst = 1'b1; ready = 1'b1;
    @(negedge clk);
    chk("t7_rst_port", 64'(Port_S2E), 64'd0);
    chk("t7_rst_ready", 64'(IssueReady), 64'd0);
    chk("t7_rst_illegal", 64'(IllegalFU), 64'd0);
    cyc(); rst = 1'b0;
    @(negedge clk);
    chk("t7_after_port", 64'(Port_S2E), 64'd0);
    chk("t7_after_illegal", 64'(IllegalFU), 64'd0);
    chk("t7_after_ready", 64'(IssueReady), 64'd1);
    cyc();
    repeat (2) cyc();

    chk("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
